// File: rtl/alu_exec_unit_if.sv
// Execute-unit bus: instruction handshake, data-memory request/grant port,
// write-back/completion outputs and the register-file debug read port.
interface alu_exec_unit_if #(parameter int DATA_W = 32);
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ovf;
  logic              err;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  // master: fetch/memory/debug environment; slave: the execute unit
  modport master (
    output inst_valid, inst, mem_gnt, mem_rvalid, mem_rdata, dbg_addr,
    input  inst_ready, mem_req, mem_we, mem_addr, mem_wdata,
           done, wb_en, wb_reg, wb_data, ovf, err, dbg_data
  );
  modport slave (
    input  inst_valid, inst, mem_gnt, mem_rvalid, mem_rdata, dbg_addr,
    output inst_ready, mem_req, mem_we, mem_addr, mem_wdata,
           done, wb_en, wb_reg, wb_data, ovf, err, dbg_data
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle MIPS-subset execute unit: one instruction per handshake, ALU ops
// in 3 cycles, lw/sw through a request/grant memory port, one-cycle done pulse.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] EXEC     = 3'd1;
  localparam logic [2:0] MEM      = 3'd2;
  localparam logic [2:0] MEM_WAIT = 3'd3;
  localparam logic [2:0] WB       = 3'd4;

  logic [2:0]        state;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] wb_data_q, addr_q, wdata_q;
  logic [4:0]        wb_reg_q;
  logic              wr_q, ovf_q, err_q, st_q;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] op_a, op_b, simm, sum_r, diff_r, sum_i;
  logic [DATA_W-1:0] res_c;
  logic [4:0]        dst_c;
  logic              ovf_c, err_c, wr_c, mem_c, st_c;

  assign opcode = inst_q[31:26];
  assign rs     = inst_q[25:21];
  assign rt     = inst_q[20:16];
  assign rd     = inst_q[15:11];
  assign funct  = inst_q[5:0];
  assign simm   = DATA_W'($signed(inst_q[15:0]));
  assign op_a   = regs[rs];
  assign op_b   = regs[rt];
  assign sum_r  = op_a + op_b;
  assign diff_r = op_a - op_b;
  assign sum_i  = op_a + simm;

  always_comb begin
    res_c = '0;
    dst_c = rd;
    ovf_c = 1'b0;
    err_c = 1'b0;
    wr_c  = 1'b0;
    mem_c = 1'b0;
    st_c  = 1'b0;
    case (opcode)
      6'b000000: begin
        wr_c = 1'b1;
        case (funct)
          6'b100000: begin
            res_c = sum_r;
            ovf_c = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_r[DATA_W-1] != op_a[DATA_W-1]);
          end
          6'b100010: begin
            res_c = diff_r;
            ovf_c = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff_r[DATA_W-1] != op_a[DATA_W-1]);
          end
          6'b100100: res_c = op_a & op_b;
          6'b100101: res_c = op_a | op_b;
          6'b101010: res_c = DATA_W'($signed(op_a) < $signed(op_b));
          default: begin
            err_c = 1'b1;
            wr_c  = 1'b0;
          end
        endcase
      end
      6'b001000: begin
        dst_c = rt;
        wr_c  = 1'b1;
        res_c = sum_i;
        ovf_c = (op_a[DATA_W-1] == simm[DATA_W-1]) && (sum_i[DATA_W-1] != op_a[DATA_W-1]);
      end
      6'b100011, 6'b101011: begin
        // misaligned accesses complete straight away with err and no request
        dst_c = rt;
        res_c = sum_i;
        st_c  = opcode[3];
        err_c = (sum_i[1:0] != 2'b00);
        mem_c = ~err_c;
        wr_c  = ~err_c & ~st_c;
      end
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inst_q    <= '0;
      wb_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_reg_q  <= '0;
      wr_q      <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      st_q      <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.inst_valid) begin
          inst_q <= bus.inst;
          state  <= EXEC;
        end
        EXEC: begin
          wb_reg_q  <= dst_c;
          wb_data_q <= res_c;
          wr_q      <= wr_c;
          ovf_q     <= ovf_c;
          err_q     <= err_c;
          st_q      <= st_c;
          if (mem_c) begin
            addr_q  <= res_c;
            wdata_q <= op_b;
          end
          state <= mem_c ? MEM : WB;
        end
        MEM: if (bus.mem_gnt) state <= st_q ? WB : MEM_WAIT;
        MEM_WAIT: if (bus.mem_rvalid) begin
          wb_data_q <= bus.mem_rdata;
          state     <= WB;
        end
        WB: begin
          if (bus.wb_en) regs[wb_reg_q] <= wb_data_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inst_ready = (state == IDLE);
  assign bus.mem_req    = (state == MEM);
  assign bus.mem_we     = (state == MEM) & st_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.done       = (state == WB);
  assign bus.wb_en      = (state == WB) & wr_q & (wb_reg_q != 5'd0);
  assign bus.wb_reg     = wb_reg_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.ovf        = (state == WB) & ovf_q;
  assign bus.err        = (state == WB) & err_q;
  assign bus.dbg_data   = regs[bus.dbg_addr];
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomized bench for alu_exec_unit with an arithmetic reference
// model (signed 64-bit math for results/overflow) and a modelled memory port.
module tb_alu_exec_unit;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  alu_exec_unit_if #(.DATA_W(32)) bus ();
  alu_exec_unit #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic [4:0]  dst;
    logic        wr;
    logic        ovf;
    logic        err;
    logic        mem;
    logic        st;
  } exp_t;

  logic [31:0] mregs [32];
  logic [31:0] last_data;
  logic        last_ovf, last_err, last_wben;
  logic [4:0]  last_reg;
  logic        last_req;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = 5'(rs); t = 5'(rt); d = 5'(rd);
    return {6'b000000, s, t, d, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    logic [4:0] s, t;
    logic [15:0] im;
    s = 5'(rs); t = 5'(rt); im = 16'(imm);
    return {op, s, t, im};
  endfunction

  // Reference: 64-bit signed arithmetic; overflow is "true sum out of int32 range".
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    longint a, b, s;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    a  = longint'($signed(mregs[ins[25:21]]));
    e  = '0;
    if (op == 6'd0) begin
      b = longint'($signed(mregs[ins[20:16]]));
      e.dst = ins[15:11];
      e.wr  = 1'b1;
      case (fn)
        6'h20: s = a + b;
        6'h22: s = a - b;
        6'h24: s = a & b;
        6'h25: s = a | b;
        6'h2a: s = (a < b) ? 64'sd1 : 64'sd0;
        default: begin s = 0; e.err = 1'b1; e.wr = 1'b0; end
      endcase
      e.data = s[31:0];
      if (fn == 6'h20 || fn == 6'h22) e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      b = longint'($signed(ins[15:0]));
      s = a + b;
      e.dst = ins[20:16];
      if (op == 6'h08) begin
        e.data = s[31:0];
        e.wr   = 1'b1;
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (op == 6'h23 || op == 6'h2b) begin
        e.addr = s[31:0];
        e.st   = (op == 6'h2b);
        e.err  = (e.addr % 4) != 0;
        e.mem  = !e.err;
        e.wr   = !e.err && !e.st;
      end else begin
        e.err = 1'b1;
      end
    end
    if (e.dst == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  // Issue one instruction; memory grant after gd request cycles, read data after rd wait cycles.
  task automatic run(input logic [31:0] ins, input int gd, input int rd, input logic [31:0] rdata);
    exp_t e;
    int   lat, req_cnt, wait_cnt, n;
    bit   got, waiting, seen_req;
    e = model(ins);
    lat = e.mem ? (e.st ? 2 + gd : 3 + gd + rd) : 1;
    req_cnt = 0; wait_cnt = 0; got = 0; waiting = 0; seen_req = 0;
    if (e.mem && !e.st) e.data = rdata;
    check("inst_ready_idle", bus.inst_ready, 1);
    bus.inst = ins;
    bus.inst_valid = 1'b1;
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    bus.inst = $urandom;
    for (n = 0; n < 40; n++) begin
      if (bus.done) begin got = 1; break; end
      check("ovf_idle", bus.ovf, 0);
      check("err_idle", bus.err, 0);
      if (bus.mem_req) begin
        seen_req = 1;
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_we", bus.mem_we, e.st);
        if (e.st) check("mem_wdata", bus.mem_wdata, mregs[ins[20:16]]);
        bus.mem_gnt = (req_cnt == gd);
        req_cnt++;
      end else begin
        bus.mem_gnt = 1'b0;
      end
      if (waiting) begin
        bus.mem_rvalid = (wait_cnt == rd);
        bus.mem_rdata  = (wait_cnt == rd) ? rdata : $urandom;
        wait_cnt++;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
      if (bus.mem_gnt && !e.st) waiting = 1;
      @(posedge clk); #1;
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency", n, lat);
    check("wb_en", bus.wb_en, e.wr);
    check("ovf", bus.ovf, e.ovf);
    check("err", bus.err, e.err);
    check("mem_req_seen", seen_req, e.mem);
    if (e.wr) check("wb_reg", bus.wb_reg, e.dst);
    if (!e.err && !e.st) check("wb_data", bus.wb_data, e.data);
    last_data = bus.wb_data; last_ovf = bus.ovf; last_err = bus.err;
    last_wben = bus.wb_en; last_reg = bus.wb_reg; last_req = seen_req;
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("wb_en_pulse", bus.wb_en, 0);
    check("ovf_after", bus.ovf, 0);
    check("err_after", bus.err, 0);
    if (e.wr) mregs[e.dst] = e.data;
    bus.dbg_addr = e.dst;
    #1;
    check("dbg_dst", bus.dbg_data, mregs[e.dst]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [5];
    logic [31:0] ins, r7_before;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    rst_n = 1'b0;
    bus.inst_valid = 1'b0; bus.inst = '0; bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.dbg_addr = '0;
    #3;
    check("rst_inst_ready", bus.inst_ready, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_done", bus.done, 0);
    check("rst_wb_en", bus.wb_en, 0);
    check("rst_wb_reg", bus.wb_reg, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run(itype(6'h08, 0, 1, 5), 0, 0, 0);
    run(itype(6'h08, 0, 2, -3), 0, 0, 0);
    run(rtype(1, 2, 3, 6'h20), 0, 0, 0);
    check("add_r3_value", last_data, 32'd2);
    check("add_r3_ovf", last_ovf, 0);

    run(itype(6'h23, 0, 1, 12), 1, 1, 32'h7FFF_FFFF);
    run(rtype(1, 1, 4, 6'h20), 0, 0, 0);
    check("add_ovf_value", last_data, 32'hFFFF_FFFE);
    check("add_ovf_flag", last_ovf, 1);
    run(rtype(0, 1, 5, 6'h22), 0, 0, 0);
    check("sub_value", last_data, 32'h8000_0001);
    check("sub_ovf", last_ovf, 0);
    run(rtype(2, 1, 6, 6'h2a), 0, 0, 0);
    check("slt_value", last_data, 32'd1);

    run(itype(6'h2b, 0, 1, 8), 3, 0, 0);
    check("sw_wb_en", last_wben, 0);
    run(itype(6'h23, 0, 7, 8), 0, 2, 32'h1234);
    check("lw_value", last_data, 32'h1234);
    check("lw_reg", last_reg, 5'd7);
    r7_before = mregs[7];
    run(itype(6'h23, 0, 7, 2), 0, 0, 0);
    check("misalign_err", last_err, 1);
    check("misalign_no_req", last_req, 0);
    bus.dbg_addr = 5'd7; #1;
    check("misalign_r7", bus.dbg_data, r7_before);
    run(rtype(1, 1, 9, 6'h07), 0, 0, 0);
    check("bad_funct_err", last_err, 1);
    run(rtype(1, 1, 0, 6'h20), 0, 0, 0);
    check("r0_wb_en", last_wben, 0);
    bus.dbg_addr = 5'd0; #1;
    check("r0_reads_zero", bus.dbg_data, 0);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0, 1: ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)]);
        2: ins = itype(6'h08, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        3: ins = itype(6'h23, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1023));
        4: ins = itype(6'h2b, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1023));
        default: ins = {6'($urandom), 26'($urandom)};
      endcase
      run(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    bus.inst = itype(6'h2b, 0, 1, 16);
    bus.inst_valid = 1'b1;
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_mem_req_before", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_ready", bus.inst_ready, 1);
    check("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i); #1;
      check("post_rst_reg", bus.dbg_data, 0);
    end
    @(posedge clk); #1;
    run(itype(6'h08, 0, 3, 77), 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
